mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NCH, default 3: number of requester channels, 2..8.
REQ-002 Parameter ADDR_W, default 32: requester and memory address width.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rdy  in  1  global ready; low freezes the block.
REQ-006 io_buffer_full  in  1  UART buffer full.
REQ-007 mem_din  in  8  memory read byte, valid the cycle after its address.
REQ-008 mem_dout  out  8  memory write byte.
REQ-009 mem_a  out  ADDR_W  memory byte address.
REQ-010 mem_wr  out  1  1 = write, 0 = read.
REQ-011 req_rn  in  NCH  per-channel read request, level, held until its ready.
REQ-012 req_wn  in  NCH  per-channel write request, level, held until its ready.
REQ-013 req_len  in  2*NCH  per-channel size: 00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes.
REQ-014 req_addr  in  ADDR_W*NCH  per-channel base byte address.
REQ-015 req_wdata  in  32*NCH  per-channel write data, little-endian.
REQ-016 gnt_ready  out  NCH  one-cycle done pulse, one-hot.
REQ-017 rdata  out  32  read result, valid in the gnt_ready cycle, zero-extended.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 States SHALL be IDLE, RD, WR, DONE.
REQ-020 IDLE: if any channel requests, register the winner, its address, length and data, then enter RD or WR; otherwise stay in IDLE.
REQ-021 A channel with both req_rn and req_wn high SHALL be served as a write.
REQ-022 Byte count L is 1, 2 or 4; byte k (k = 0..L-1) uses address base+k, with ADDR_W wrap-around.
REQ-023 RD issues byte k in RD cycle k with mem_wr=0; mem_din captured the next cycle goes into rdata[8k+7:8k]; after the last capture the block enters DONE.
REQ-024 WR drives mem_a=base+k, mem_dout=byte k, mem_wr=1 in WR cycle k; after byte L-1 the block enters DONE.
REQ-025 Latency from the request-sampling edge to gnt_ready high SHALL be L+2 cycles for reads and L+1 cycles for writes.
REQ-026 DONE: pulse gnt_ready[winner] for one cycle with rdata stable, then return to IDLE; requests are sampled only in IDLE.
REQ-027 While rdy is low, all state and counters SHALL freeze and mem_wr SHALL be 0; a read byte whose data cycle falls in a rdy-low period SHALL be reissued.
REQ-028 IO stall: for a write byte with address bits [17:16]==2'b11 while io_buffer_full=1, hold the byte, drive mem_wr=0, and retry each cycle.
REQ-029 Outside RD/WR, mem_wr SHALL be 0 and mem_a SHALL be 0.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, mem_a=0, mem_dout=0, mem_wr=0, gnt_ready=0, rdata=0, busy=0 and arbitration pointer=0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no gnt_ready pulse; the requester re-issues after reset.

Configuration
REQ-032 With MEM_ARB_RR_EN defined: round-robin; the search starts at pointer, and the pointer becomes winner+1 mod NCH on each grant.
REQ-033 Without MEM_ARB_RR_EN: fixed priority, lowest channel index wins, and no pointer register exists.

Verification
REQ-034 Ch1 4-byte read at 0x100, memory bytes 11 22 33 44 -> mem_a 0x100..0x103, gnt_ready=3'b010 at cycle 6, rdata=0x44332211.
REQ-035 Ch0 2-byte write 0xBEEF to 0x20 -> mem_wr=1 cycles 1-2 with (0x20,EF), (0x21,BE); gnt_ready[0] at cycle 3.
REQ-036 Ch0-ch2 all request 1-byte reads continuously, RR build -> grant order 0,1,2,0; non-RR build -> grant 0 repeatedly.
REQ-037 1-byte write 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr=0 for those 3 cycles, then 1 for one cycle, then gnt_ready.
REQ-038 rdy low for 2 cycles mid 4-byte read, then rst_n pulse during a later write -> read completes with correct data; write aborted, all outputs 0, no gnt_ready.

Source files
------------

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates NCH byte-serial requesters onto one 8-bit memory port.
//            Each request moves 1, 2 or 4 bytes little-endian. Reads return
//            a zero-extended 32-bit word together with a one-cycle, one-hot
//            gnt_ready pulse.
// Options  : MEM_ARB_RR_EN - when defined, round-robin arbitration with a
//            rotating pointer; otherwise fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int NCH    = 3,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_W-1:0]     mem_a,
  output logic                  mem_wr,
  input  logic [NCH-1:0]        req_rn,
  input  logic [NCH-1:0]        req_wn,
  input  logic [2*NCH-1:0]      req_len,
  input  logic [ADDR_W*NCH-1:0] req_addr,
  input  logic [32*NCH-1:0]     req_wdata,
  output logic [NCH-1:0]        gnt_ready,
  output logic [31:0]           rdata,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NCH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Transaction registers captured when a winner is chosen.
  logic [IDX_W-1:0]  r_win;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_lenm1;   // byte count minus one: 0, 1 or 3
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  // r_cnt: index of the next byte to issue. For reads, r_pend marks that a
  // byte was issued last cycle and its data is on mem_din this cycle.
  logic [2:0]        r_cnt;
  logic              r_pend;

  logic [NCH-1:0]    w_req;
  logic              w_any;
  logic [IDX_W-1:0]  w_win;
  logic [2:0]        w_len;
  logic [2:0]        w_cnt_m1;
  logic [1:0]        w_cap_idx;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wbyte;
  logic              w_stall;
  logic              w_grant;
  logic [1:0]        w_req_len;

  assign w_req     = req_rn | req_wn;
  assign w_len     = {1'b0, r_lenm1} + 3'd1;
  assign w_cnt_m1  = r_cnt - 3'd1;
  assign w_cap_idx = w_cnt_m1[1:0];
  assign w_addr    = r_base + ADDR_W'(r_cnt);
  assign w_wbyte   = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
  assign w_grant   = (r_state == S_IDLE) && rdy && w_any;
  assign w_req_len = req_len[w_win*2 +: 2];

  // IO-mapped writes (address bits [17:16] == 2'b11) stall while the UART
  // buffer is full; narrow address spaces cannot reach that region.
  generate
    if (ADDR_W >= 18) begin : g_io_stall
      assign w_stall = (w_addr[17:16] == 2'b11) && io_buffer_full;
    end else begin : g_no_io_stall
      assign w_stall = 1'b0;
    end
  endgenerate

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;
  int               w_idx;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int i = NCH-1; i >= 0; i--) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NCH) w_idx = w_idx - NCH;
      if (w_req[w_idx]) begin
        w_any = 1'b1;
        w_win = IDX_W'(w_idx);
      end
    end
  end

  // Pointer moves to the channel after the winner on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_win == IDX_W'(NCH-1)) ? '0 : w_win + IDX_W'(1);
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_any = 1'b1;
        w_win = IDX_W'(i);
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and memory-port/handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    mem_a       = '0;
    mem_dout    = '0;
    mem_wr      = 1'b0;
    gnt_ready   = '0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = req_wn[w_win] ? S_WR : S_RD;
        end
      end
      S_RD: begin
        mem_a = w_addr;
        if (rdy && r_pend && (r_cnt == w_len)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WR: begin
        mem_a    = w_addr;
        mem_dout = w_wbyte;
        mem_wr   = rdy && !w_stall;
        if (rdy && !w_stall && (r_cnt == {1'b0, r_lenm1})) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        gnt_ready[r_win] = rdy;
        if (rdy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Transaction capture, byte counters and read-data assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win   <= '0;
      r_base  <= '0;
      r_lenm1 <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_win   <= w_win;
            r_base  <= req_addr[w_win*ADDR_W +: ADDR_W];
            r_lenm1 <= w_req_len[1] ? 2'd3 : {1'b0, w_req_len[0]};
            r_wdata <= req_wdata[w_win*32 +: 32];
            r_rdata <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
          end
        end
        S_RD: begin
          if (rdy) begin
            if (r_pend) begin
              r_rdata[{w_cap_idx, 3'b000} +: 8] <= mem_din;
            end
            if (r_cnt != w_len) begin
              r_cnt  <= r_cnt + 3'd1;
              r_pend <= 1'b1;
            end else begin
              r_pend <= 1'b0;
            end
          end else if (r_pend) begin
            // Data cycle lost to rdy low: step back so the byte is reissued.
            r_cnt  <= w_cnt_m1;
            r_pend <= 1'b0;
          end
        end
        S_WR: begin
          if (rdy && !w_stall && (r_cnt != {1'b0, r_lenm1})) begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scoreboard bench for mem_arbiter (NCH=3, ADDR_W=32).
//            Stimulus pushes expected grants and expected memory writes into
//            queues; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 32;

  typedef struct {
    logic [2:0]  gnt;
    logic [31:0] rdata;
    int          cyc;
  } gnt_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rdy;
  logic              io_buffer_full;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [AW-1:0]     mem_a;
  logic              mem_wr;
  logic [NCH-1:0]    req_rn;
  logic [NCH-1:0]    req_wn;
  logic [2*NCH-1:0]  req_len;
  logic [AW*NCH-1:0] req_addr;
  logic [32*NCH-1:0] req_wdata;
  logic [NCH-1:0]    gnt_ready;
  logic [31:0]       rdata;
  logic              busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  gnt_t gq[$];
  wr_t  wq[$];
  logic [7:0] mem [0:4095];

  mem_arbiter #(.NCH(NCH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .req_rn(req_rn), .req_wn(req_wn), .req_len(req_len),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt_ready(gnt_ready), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous read (data valid the cycle after the address).
  always @(posedge clk) begin
    if (mem_wr) mem[mem_a[11:0]] <= mem_dout;
    mem_din <= mem[mem_a[11:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every grant pulse and every memory write.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (gnt_ready !== 3'b000) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", 32'(gnt_ready), 32'h0);
        end else begin
          gnt_t e;
          e = gq.pop_front();
          chk("gnt_ready", 32'(gnt_ready), 32'(e.gnt));
          chk("rdata", rdata, e.rdata);
          chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (mem_wr === 1'b1) begin
        if (wq.size() == 0) begin
          chk("unexpected_wr", mem_a, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", mem_a, w.addr);
          chk("wr_data", 32'(mem_dout), 32'(w.data));
        end
      end
    end
  end

  task automatic push_g(input logic [2:0] g, input logic [31:0] d, input int c);
    gnt_t e;
    e.gnt = g; e.rdata = d; e.cyc = c;
    gq.push_back(e);
  endtask

  task automatic push_w(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  // Presents a request just after a rising edge; it is sampled at the next one.
  task automatic start_req(input int ch, input bit rd, input bit wr, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    req_rn[ch]              = rd;
    req_wn[ch]              = wr;
    req_len[2*ch +: 2]      = len;
    req_addr[32*ch +: 32]   = addr;
    req_wdata[32*ch +: 32]  = wd;
  endtask

  task automatic wait_gnt(input int ch);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_ready[ch] !== 1'b1 && n < 60);
    if (gnt_ready[ch] !== 1'b1) chk("gnt_timeout", 32'(ch), 32'hFFFF_FFFF);
    req_rn[ch] = 1'b0;
    req_wn[ch] = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_a"}, mem_a, 32'h0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
    chk({tag, "_mem_dout"}, 32'(mem_dout), 32'h0);
    chk({tag, "_gnt"}, 32'(gnt_ready), 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int ord [4];
    int seen;
    int n;

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    mem[12'h010] = 8'hA0; mem[12'h011] = 8'hA1; mem[12'h012] = 8'hA2;
    mem[12'h200] = 8'h55; mem[12'h201] = 8'h66; mem[12'h202] = 8'h77; mem[12'h203] = 8'h88;
    mem[12'hFFF] = 8'h5A; mem[12'h000] = 8'hC3;

    rst_n = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    req_rn = '0; req_wn = '0; req_len = '0; req_addr = '0; req_wdata = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 chk_idle_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // Ch1 4-byte read at 0x100: gnt 5 edges after sampling.
    start_req(1, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    e = cyc + 1;
    push_g(3'b010, 32'h4433_2211, e + 5);
    @(negedge clk); chk("busy_idle_before_sample", 32'(busy), 32'h0);
    wait_gnt(1);

    // Ch0 2-byte write 0xBEEF to 0x20 with both request lines high (write wins).
    start_req(0, 1'b1, 1'b1, 2'b01, 32'h20, 32'h0000_BEEF);
    e = cyc + 1;
    push_w(32'h20, 8'hEF); push_w(32'h21, 8'hBE);
    push_g(3'b001, 32'h0, e + 2);
    wait_gnt(0);

    // Ch2 2-byte read at 0xFFFFFFFF wraps to 0x0.
    start_req(2, 1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0);
    e = cyc + 1;
    push_g(3'b100, 32'h0000_C35A, e + 3);
    wait_gnt(2);

    // IO write stalled 3 cycles by io_buffer_full.
    start_req(2, 1'b0, 1'b1, 2'b00, 32'h0003_0000, 32'h41);
    io_buffer_full = 1'b1;
    e = cyc + 1;
    push_w(32'h0003_0000, 8'h41);
    push_g(3'b100, 32'h0, e + 4);
    repeat (4) @(posedge clk);
    #1 io_buffer_full = 1'b0;
    wait_gnt(2);

    // Ch0 4-byte read with rdy low for two cycles in the middle.
    start_req(0, 1'b1, 1'b0, 2'b11, 32'h200, 32'h0);
    e = cyc + 1;
    push_g(3'b001, 32'h8877_6655, e + 8);
    repeat (3) @(posedge clk);
    #1 rdy = 1'b0;
    @(negedge clk); chk("rdy_low_busy", 32'(busy), 32'h1);
    repeat (2) @(posedge clk);
    #1 rdy = 1'b1;
    wait_gnt(0);

    // Ch2 4-byte write aborted by reset after its first byte.
    start_req(2, 1'b0, 1'b1, 2'b10, 32'h300, 32'hDDCC_BBAA);
    push_w(32'h300, 8'hAA);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0; req_wn[2] = 1'b0;
    #1 chk_idle_outputs("abort");
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_busy_after", 32'(busy), 32'h0);

    // All three channels request 1-byte reads continuously.
`ifdef MEM_ARB_RR_EN
    ord = '{0, 1, 2, 0};
`else
    ord = '{0, 0, 0, 0};
`endif
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      req_rn[c] = 1'b1; req_len[2*c +: 2] = 2'b00; req_addr[32*c +: 32] = 32'h10 + 32'(c);
    end
    e = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      push_g(3'(1 << ord[k]), 32'hA0 + 32'(ord[k]), e + 2 + 4*k);
    end
    seen = 0; n = 0;
    while (seen < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (gnt_ready !== 3'b000) seen++;
    end
    req_rn = '0;
    if (seen < 4) chk("arb_timeout", 32'(seen), 32'd4);

    repeat (8) @(negedge clk);
    chk("gnt_queue_drained", 32'(gq.size()), 32'h0);
    chk("wr_queue_drained", 32'(wq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
